// File: rtl/tracer_pkg.sv
// Shared definitions for the trace-logger dump master: FSM encoding, bank layout, header sync bytes.
// Optional macro TRACER_DUMP_HDR_EN adds the per-bank header state.
package tracer_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  localparam logic [31:0]       BANK_STRIDE = 32'h1000;
  localparam logic [BYTE_W-1:0] HDR_SYNC0   = 8'hA5;
  localparam logic [BYTE_W-1:0] HDR_SYNC1   = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RD    = 3'd2,
    ST_SHIFT = 3'd3
`ifdef TRACER_DUMP_HDR_EN
    , ST_HDR = 3'd4
`endif
  } state_t;

  function automatic logic [31:0] rd_addr(input logic [31:0] base,
                                          input logic [1:0]  bank,
                                          input logic [31:0] idx);
    return base + (32'(bank) * BANK_STRIDE) + (idx << 2);
  endfunction

  // Header goes out LSB first: sync0, sync1, bank, zero.
  function automatic logic [WORD_W-1:0] hdr_word(input logic [1:0] bank);
    return {8'h00, 6'b0, bank, HDR_SYNC1, HDR_SYNC0};
  endfunction

endpackage

// File: rtl/tracer_word_ser.sv
// 32-bit word to byte stream serializer, LSB byte first, valid/ready output.
// done pulses combinationally in the cycle the last byte is accepted.
module tracer_word_ser
  import tracer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  // Handshake: a byte transfers on a cycle with tx_valid=1 and tx_ready=1;
  // tx_data holds still while tx_valid=1 and tx_ready=0.
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic              active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      shreg  <= word;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active && tx_ready) begin
      shreg <= {BYTE_W'(0), shreg[WORD_W-1:BYTE_W]};
      cnt   <= cnt + CW'(1);
      if (cnt == CW'(BYTES_PER_WORD - 1)) active <= 1'b0;
    end
  end

  assign tx_data  = shreg[BYTE_W-1:0];
  assign tx_valid = active;
  assign done     = active && tx_ready && (cnt == CW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/tracer_dump_master.sv
// Wishbone master that arms the trace logger trigger and dumps every bank as a byte stream.
// Define TRACER_DUMP_HDR_EN to prefix each bank with a 4-byte header.
module tracer_dump_master
  import tracer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          NUM_BANKS   = 4,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        arm_i,
  input  logic [31:0] trig_val_i,
  input  logic        dump_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output state_t      dbg_state_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t            state, state_n;
  logic [1:0]        bank, bank_n;
  logic [IW-1:0]     idx, idx_n;
  logic [TW-1:0]     tcnt;
  logic              timeout, err_n;
  logic              ser_load, ser_done;
  logic [WORD_W-1:0] ser_word;

  assign timeout     = (tcnt == TW'(ACK_TIMEOUT - 1));
  assign busy_o      = (state != ST_IDLE);
  assign wb_sel_o    = 4'hf;
  assign dbg_state_o = state;

  tracer_word_ser u_ser (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .load     (ser_load),
    .word     (ser_word),
    .tx_data  (tx_data_o),
    .tx_valid (tx_valid_o),
    .tx_ready (tx_ready_i),
    .done     (ser_done)
  );

  always_comb begin
    state_n  = state;
    bank_n   = bank;
    idx_n    = idx;
    ser_load = 1'b0;
    ser_word = '0;
    err_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm_i) begin
          state_n = ST_ARM;
        end else if (dump_i) begin
          bank_n = '0;
          idx_n  = '0;
`ifdef TRACER_DUMP_HDR_EN
          state_n  = ST_HDR;
          ser_load = 1'b1;
          ser_word = hdr_word(2'd0);
`else
          state_n  = ST_RD;
`endif
        end
      end
      ST_ARM: begin
        // An error wins over a same-cycle ack.
        if (wb_err_i || (!wb_ack_i && timeout)) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end else if (wb_ack_i) begin
          state_n = ST_IDLE;
        end
      end
      ST_RD: begin
        if (wb_err_i || (!wb_ack_i && timeout)) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end else if (wb_ack_i) begin
          state_n  = ST_SHIFT;
          ser_load = 1'b1;
          ser_word = wb_dat_i;
        end
      end
      ST_SHIFT: begin
        if (ser_done) begin
          if (idx == IW'(DEPTH - 1)) begin
            idx_n = '0;
            if (bank == 2'(NUM_BANKS - 1)) begin
              state_n = ST_IDLE;
            end else begin
              bank_n = bank + 2'd1;
`ifdef TRACER_DUMP_HDR_EN
              state_n  = ST_HDR;
              ser_load = 1'b1;
              ser_word = hdr_word(bank + 2'd1);
`else
              state_n  = ST_RD;
`endif
            end
          end else begin
            idx_n   = idx + IW'(1);
            state_n = ST_RD;
          end
        end
      end
`ifdef TRACER_DUMP_HDR_EN
      ST_HDR: begin
        if (ser_done) state_n = ST_RD;
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so a reset clears them at once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state    <= ST_IDLE;
      bank     <= '0;
      idx      <= '0;
      tcnt     <= '0;
      err_o    <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      state    <= state_n;
      bank     <= bank_n;
      idx      <= idx_n;
      err_o    <= err_n;
      tcnt     <= ((state_n == state) && ((state == ST_ARM) || (state == ST_RD)))
                  ? tcnt + TW'(1) : '0;
      wb_cyc_o <= (state_n == ST_ARM) || (state_n == ST_RD);
      wb_stb_o <= (state_n == ST_ARM) || (state_n == ST_RD);
      wb_we_o  <= (state_n == ST_ARM);
      if ((state == ST_IDLE) && arm_i) wb_dat_o <= trig_val_i;
      if (state_n == ST_ARM)     wb_adr_o <= BASE_ADDR;
      else if (state_n == ST_RD) wb_adr_o <= rd_addr(BASE_ADDR, bank_n, 32'(idx_n));
    end
  end

endmodule

// File: tb/tb_tracer_dump_master.sv
// Directed bench for tracer_dump_master: arm write, full dump, back-pressure,
// timeouts/errors, arbitration and mid-operation reset.
module tb_tracer_dump_master;
  import tracer_pkg::*;

`ifdef TRACER_DUMP_HDR_EN
  localparam int HDR_B = 4;
  localparam int NCHK  = 28;
  int         chk_off [NCHK] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
                                 4100, 4101, 4102, 4103, 4104, 4105, 4106, 4107,
                                 12300, 12301, 12302, 12303, 16396, 16397, 16398, 16399};
  logic [7:0] chk_val [NCHK] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                 8'h04, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'h01, 8'h00,
                                 8'h00, 8'h10, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'h03, 8'h00,
                                 8'hFC, 8'h3F, 8'h00, 8'h00};
`else
  localparam int HDR_B = 0;
  localparam int NCHK  = 16;
  int         chk_off [NCHK] = '{0, 1, 2, 3, 4, 5, 6, 7, 4096, 4097, 4098, 4099,
                                 16380, 16381, 16382, 16383};
  logic [7:0] chk_val [NCHK] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00,
                                 8'h00, 8'h10, 8'h00, 8'h00, 8'hFC, 8'h3F, 8'h00, 8'h00};
`endif
  localparam int TOTAL_BYTES = 4 * (HDR_B + 1024 * 4);

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm_i = 1'b0, dump_i = 1'b0, tx_ready_i = 1'b0;
  logic [31:0] trig_val_i = '0;
  logic        busy_o, err_o, wb_we_o, wb_cyc_o, wb_stb_o, tx_valid_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i;
  logic [7:0]  tx_data_o;
  state_t      dbg_state;

  always #5 clk = ~clk;

  tracer_dump_master dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .arm_i(arm_i), .trig_val_i(trig_val_i),
    .dump_i(dump_i), .busy_o(busy_o), .err_o(err_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .dbg_state_o(dbg_state)
  );

  // ---------------- slave model: ack one cycle after strobe, data = address ----------------
  logic        hang_en = 1'b0, err_on_wr = 1'b0;
  logic [31:0] hang_addr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      wb_dat_i <= '0;
    end else begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
        if (wb_we_o && err_on_wr) wb_err_i <= 1'b1;
        else if (!(hang_en && !wb_we_o && wb_adr_o == hang_addr)) begin
          wb_ack_i <= 1'b1;
          wb_dat_i <= wb_adr_o;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0, errors = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          wr_txn, rd_txn, err_pulses, hang_cycles, stab_bad, wr_bad, ack_busy_bad;
  logic        timed_out;
  logic [31:0] exp_trig;

  task automatic build_exp(input int nwords);
    logic [31:0] w;
    exp_q.delete();
    for (int k = 0; k < nwords; k++) begin
      if ((k % 1024) == 0 && HDR_B != 0) begin
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        exp_q.push_back(8'(k / 1024)); exp_q.push_back(8'h00);
      end
      w = 32'((k / 1024) * 32'h1000 + (k % 1024) * 4);
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  // ---------------- driver: start an operation and observe until idle ----------------
  task automatic run_op(input logic a, input logic d, input logic [31:0] tv,
                        input int late_dump, input int low_pct, input int budget);
    int n;
    logic hold, prev_cyc, prev_wack;
    logic [7:0] hold_d;
    got_q.delete();
    wr_txn = 0; rd_txn = 0; err_pulses = 0; hang_cycles = 0;
    stab_bad = 0; wr_bad = 0; ack_busy_bad = 0; exp_trig = tv;
    n = 0; hold = 1'b0; hold_d = '0; prev_cyc = 1'b0; prev_wack = 1'b0;
    @(negedge clk);
    tx_ready_i = 1'b0; arm_i = a; dump_i = d; trig_val_i = tv;
    do begin
      @(negedge clk);
      arm_i = 1'b0; trig_val_i = '0; dump_i = (n == late_dump);
      tx_ready_i = ($urandom_range(99, 0) >= low_pct);
      if (wb_cyc_o && !prev_cyc) begin
        if (wb_we_o) wr_txn++; else rd_txn++;
      end
      if (wb_cyc_o && wb_we_o && (wb_adr_o !== 32'h0 || wb_dat_o !== exp_trig ||
                                  wb_sel_o !== 4'hf || wb_stb_o !== 1'b1)) wr_bad++;
      if (prev_wack && busy_o) ack_busy_bad++;
      if (err_o) err_pulses++;
      if (hang_en && wb_cyc_o && wb_adr_o == hang_addr) hang_cycles++;
      if (hold && (!tx_valid_o || tx_data_o !== hold_d)) stab_bad++;
      if (tx_valid_o && tx_ready_i) got_q.push_back(tx_data_o);
      hold = tx_valid_o && !tx_ready_i;
      hold_d = tx_data_o;
      prev_cyc = wb_cyc_o;
      prev_wack = wb_ack_i && wb_we_o && wb_cyc_o;
      n++;
    end while ((busy_o || n <= late_dump) && n < budget);
    timed_out = busy_o;
    dump_i = 1'b0;
    tx_ready_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, tx_valid_o, busy_o, err_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {wb_cyc_o, wb_stb_o, wb_we_o, tx_valid_o, busy_o, err_o});
    end
    checks++;
    if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got adr %h dat %h expected 0", wb_adr_o, wb_dat_o);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_arm();
    run_op(1'b1, 1'b0, 32'hDEAD_BEEF, -1, 0, 100);
    checks++;
    if (timed_out || wr_txn != 1 || rd_txn != 0) begin
      errors++;
      $display("FAIL arm_txn: got timeout %0b wr %0d rd %0d expected 0 1 0", timed_out, wr_txn, rd_txn);
    end
    checks++;
    if (wr_bad != 0) begin
      errors++;
      $display("FAIL arm_fields: got %0d bad write cycles expected 0", wr_bad);
    end
    checks++;
    if (ack_busy_bad != 0 || err_pulses != 0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL arm_done: got busy_after_ack %0d err %0d bytes %0d expected 0 0 0",
               ack_busy_bad, err_pulses, got_q.size());
    end
  endtask

  task automatic test_dump();
    run_op(1'b0, 1'b1, 32'h0, -1, 0, 40000);
    build_exp(4096);
    checks++;
    if (timed_out || got_q.size() != TOTAL_BYTES || rd_txn != 4096 || err_pulses != 0) begin
      errors++;
      $display("FAIL dump_len: got timeout %0b bytes %0d reads %0d err %0d expected 0 %0d 4096 0",
               timed_out, got_q.size(), rd_txn, err_pulses, TOTAL_BYTES);
    end
    for (int i = 0; i < NCHK; i++) begin
      checks++;
      if (got_q.size() <= chk_off[i] || got_q[chk_off[i]] !== chk_val[i]) begin
        errors++;
        $display("FAIL dump_byte[%0d]: got %h expected %h", chk_off[i],
                 (got_q.size() > chk_off[i]) ? got_q[chk_off[i]] : 8'hxx, chk_val[i]);
      end
    end
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL dump_stream: got %0d bytes expected %0d matching model", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    run_op(1'b0, 1'b1, 32'h0, -1, 30, 60000);
    build_exp(4096);
    checks++;
    if (timed_out || got_q != exp_q) begin
      errors++;
      $display("FAIL bp_stream: got timeout %0b bytes %0d expected 0 %0d matching model",
               timed_out, got_q.size(), exp_q.size());
    end
    checks++;
    if (stab_bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable hold cycles expected 0", stab_bad);
    end
  endtask

  task automatic test_timeout();
    hang_en = 1'b1; hang_addr = 32'h14;
    run_op(1'b0, 1'b1, 32'h0, -1, 0, 2000);
    hang_en = 1'b0;
    build_exp(5);
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL to_bytes: got %0d bytes expected %0d matching model", got_q.size(), exp_q.size());
    end
    checks++;
    if (hang_cycles != 255 || err_pulses != 1) begin
      errors++;
      $display("FAIL to_count: got cyc %0d err %0d expected 255 1", hang_cycles, err_pulses);
    end
    checks++;
    if (timed_out || wb_cyc_o || wb_stb_o || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL to_idle: got busy %0b cyc %0b stb %0b state %0d expected 0 0 0 0",
               timed_out, wb_cyc_o, wb_stb_o, dbg_state);
    end
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: got err_o %b expected 0", err_o);
    end
    err_on_wr = 1'b1;
    run_op(1'b1, 1'b0, 32'h1234_5678, -1, 0, 100);
    err_on_wr = 1'b0;
    checks++;
    if (timed_out || err_pulses != 1 || wr_txn != 1 || wb_cyc_o || wb_stb_o || got_q.size() != 0) begin
      errors++;
      $display("FAIL arm_err: got busy %0b err %0d wr %0d cyc %0b bytes %0d expected 0 1 1 0 0",
               timed_out, err_pulses, wr_txn, wb_cyc_o, got_q.size());
    end
  endtask

  task automatic test_arbitration();
    run_op(1'b1, 1'b1, 32'hCAFE_F00D, -1, 0, 100);
    checks++;
    if (timed_out || wr_txn != 1 || rd_txn != 0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL arb_same: got busy %0b wr %0d rd %0d bytes %0d expected 0 1 0 0",
               timed_out, wr_txn, rd_txn, got_q.size());
    end
    run_op(1'b1, 1'b0, 32'h0BAD_F00D, 0, 0, 100);
    repeat (3) @(negedge clk);
    checks++;
    if (timed_out || wr_txn != 1 || rd_txn != 0 || busy_o || wb_cyc_o) begin
      errors++;
      $display("FAIL arb_busy: got wr %0d rd %0d busy %0b cyc %0b expected 1 0 0 0",
               wr_txn, rd_txn, busy_o, wb_cyc_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk); tx_ready_i = 1'b0; dump_i = 1'b1;
      @(negedge clk); dump_i = 1'b0;
      n = 0;
      while (((s == 0) ? !wb_cyc_o : !tx_valid_o) && n < 20) begin
        @(negedge clk); n++;
      end
      checks++;
      if (n >= 20) begin
        errors++;
        $display("FAIL rst_reach[%0d]: got no activity in %0d cycles expected activity", s, n);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (wb_cyc_o || wb_stb_o || tx_valid_o || busy_o || dbg_state !== ST_IDLE) begin
        errors++;
        $display("FAIL rst_async[%0d]: got cyc %0b stb %0b valid %0b busy %0b expected 0 0 0 0",
                 s, wb_cyc_o, wb_stb_o, tx_valid_o, busy_o);
      end
      @(negedge clk); rst_n = 1'b1;
      tx_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (wb_cyc_o || tx_valid_o || busy_o) begin
        errors++;
        $display("FAIL rst_resume[%0d]: got cyc %0b valid %0b busy %0b expected 0 0 0",
                 s, wb_cyc_o, tx_valid_o, busy_o);
      end
      tx_ready_i = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_dump();
    test_backpressure();
    test_timeout();
    test_arbitration();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
